// File: rtl/snoop_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snoop_request_ctrl
// Description : Initiator side of the L1-to-L1 snoop protocol. On a local
//               miss or upgrade it broadcasts a snoop command to the peer L1.
//               It collects the peer response and falls back to a memory
//               fetch when the peer misses. Completion is reported to the
//               local MOESI logic with a one-cycle done pulse, fetch-source
//               flags and the fill data.
// Options     : SNOOP_TIMEOUT_EN - S_WAIT watchdog. After TIMEOUT_CYC cycles
//               with no response, the peer is treated as a miss and the
//               sticky timeout_err flag is set.
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_request_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              snoop_valid,
    output logic [3:0]        snoop_cmd,
    output logic [ADDR_W-1:0] snoop_addr,
    input  logic              snoop_ready,
    input  logic              resp_valid,
    input  logic              resp_hit,
    input  logic [DATA_W-1:0] resp_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              done,
    output logic              is_bus_fetch,
    output logic              is_mem_fetch,
    output logic [DATA_W-1:0] fill_data,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        M_REQ  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] c_cmd_read     = 4'b0001;
    localparam logic [3:0] c_cmd_read_inv = 4'b0111;
    localparam logic [3:0] c_cmd_inv      = 4'b1101;
    localparam logic [1:0] c_type_upgrade = 2'd2;
    localparam logic [1:0] c_type_rsvd    = 2'd3;

    state_t            state_q;
    logic              upgrade_q;
    logic              req_ready_q;
    logic              snoop_valid_q;
    logic [3:0]        snoop_cmd_q;
    logic [ADDR_W-1:0] snoop_addr_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              done_q;
    logic              is_bus_fetch_q;
    logic              is_mem_fetch_q;
    logic [DATA_W-1:0] fill_data_q;
    logic              timeout_hit;

    // Only request types 0..2 reach this; type 3 is filtered at accept.
    function automatic logic [3:0] cmd_for(input logic [1:0] t);
        case (t)
            2'd0:    cmd_for = c_cmd_read;
            2'd1:    cmd_for = c_cmd_read_inv;
            default: cmd_for = c_cmd_inv;
        endcase
    endfunction

`ifdef SNOOP_TIMEOUT_EN
    localparam int               CNT_W      = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             timeout_err_q;

    // Counter is held at zero outside S_WAIT, so every S_WAIT entry starts fresh.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Expiry fires on the TIMEOUT_CYC-th S_WAIT cycle; a response on that cycle still wins.
    assign timeout_hit = (wait_cnt_q == c_cnt_last);

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if ((state_q == S_WAIT) && !resp_valid && timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC >= 2);
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // Main protocol FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            upgrade_q      <= 1'b0;
            req_ready_q    <= 1'b1;
            snoop_valid_q  <= 1'b0;
            snoop_cmd_q    <= 4'b0000;
            snoop_addr_q   <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            done_q         <= 1'b0;
            is_bus_fetch_q <= 1'b0;
            is_mem_fetch_q <= 1'b0;
            fill_data_q    <= '0;
        end else begin
            done_q         <= 1'b0;
            is_bus_fetch_q <= 1'b0;
            is_mem_fetch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q && (req_type != c_type_rsvd)) begin
                        upgrade_q     <= (req_type == c_type_upgrade);
                        snoop_addr_q  <= req_addr;
                        snoop_cmd_q   <= cmd_for(req_type);
                        snoop_valid_q <= 1'b1;
                        req_ready_q   <= 1'b0;
                        state_q       <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Any response on the handshake cycle is deliberately not looked at.
                    if (snoop_ready) begin
                        snoop_valid_q <= 1'b0;
                        snoop_cmd_q   <= 4'b0000;
                        state_q       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_valid || timeout_hit) begin
                        if (upgrade_q) begin
                            // Peer has invalidated its copy; no data moves.
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (resp_valid && resp_hit) begin
                            fill_data_q    <= resp_data;
                            is_bus_fetch_q <= 1'b1;
                            done_q         <= 1'b1;
                            state_q        <= DONE;
                        end else begin
                            mem_addr_q <= snoop_addr_q;
                            mem_req_q  <= 1'b1;
                            state_q    <= M_REQ;
                        end
                    end
                end
                M_REQ: begin
                    if (mem_ack) begin
                        mem_req_q      <= 1'b0;
                        fill_data_q    <= mem_data;
                        is_mem_fetch_q <= 1'b1;
                        done_q         <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    snoop_valid_q <= 1'b0;
                    snoop_cmd_q   <= 4'b0000;
                    mem_req_q     <= 1'b0;
                    req_ready_q   <= 1'b1;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign snoop_valid  = snoop_valid_q;
    assign snoop_cmd    = snoop_cmd_q;
    assign snoop_addr   = snoop_addr_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign done         = done_q;
    assign is_bus_fetch = is_bus_fetch_q;
    assign is_mem_fetch = is_mem_fetch_q;
    assign fill_data    = fill_data_q;

endmodule
`default_nettype wire
